alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (legal 8..64).
REQ-002 SHALL have port: CLK  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: START  input  1  operation request; sampled only when BUSY=0.
REQ-005 SHALL have port: S_OP  input  3  opcode: 000 and, 001 or, 010 add, 110 sub, 111 slt (signed), 100 mul, 101 divu, 011 nop.
REQ-006 SHALL have port: INOP1  input  WIDTH  first operand.
REQ-007 SHALL have port: INOP2  input  WIDTH  second operand.
REQ-008 SHALL have port: RES_OP  output  WIDTH  registered result (low product / quotient for mul/divu).
REQ-009 SHALL have port: RES_HI  output  WIDTH  registered high product (mul) / remainder (divu); 0 for other ops.
REQ-010 SHALL have port: ZEROFLAG  output  1  registered, 1 when RES_OP==0.
REQ-011 SHALL have port: DIVZERO  output  1  registered, 1 when last divu had INOP2==0.
REQ-012 SHALL have port: BUSY  output  1  high while a multi-cycle operation is in progress.
REQ-013 SHALL have port: DONE  output  1  one-cycle pulse: results valid and updated.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV; IDLE->MUL on START & S_OP=100, IDLE->DIV on START & S_OP=101, MUL/DIV->IDLE after final iteration.
REQ-015 SHALL capture INOP1, INOP2, S_OP on the edge START is sampled; later operand changes do not affect the operation.
REQ-016 SHALL, for single-cycle ops (and, or, add, sub, slt, nop), update RES_OP, RES_HI=0, ZEROFLAG, DIVZERO=0 and pulse DONE on the same edge START is sampled (latency 1).
REQ-017 SHALL compute add/sub modulo 2^WIDTH, carry/overflow discarded; slt yields 1 if $signed(INOP1)<$signed(INOP2) else 0; nop yields RES_OP=0, ZEROFLAG=1.
REQ-018 SHALL compute mul unsigned by iterative shift-add, one bit per cycle, 2*WIDTH-bit product split {RES_HI,RES_OP}.
REQ-019 SHALL compute divu by restoring division, one quotient bit per cycle, quotient to RES_OP, remainder to RES_HI.
REQ-020 SHALL, for mul/divu, assert BUSY from the edge after START is sampled through the final iteration, and write results and pulse DONE exactly WIDTH edges after the START edge (latency WIDTH).
REQ-021 SHALL, on divu with INOP2==0, skip iteration, return RES_OP=all ones, RES_HI=INOP1, DIVZERO=1, DONE one edge after START.
REQ-022 SHALL ignore START while BUSY=1; outputs hold until the next completed operation.
REQ-023 SHALL hold RES_OP, RES_HI, ZEROFLAG, DIVZERO stable between DONE pulses; DONE never asserted in two consecutive cycles for one multi-cycle op.
REQ-024 SHALL accept back-to-back single-cycle ops every cycle, and a new START in the cycle DONE is high.

Reset
REQ-025 SHALL, on RST=1 at any time (including mid-mul/div), force IDLE, BUSY=0, DONE=0, RES_OP=0, RES_HI=0, DIVZERO=0, ZEROFLAG=1, iteration counter 0.
REQ-026 SHALL discard any in-flight operation on reset; no DONE follows reset release until a new START.

Configuration
REQ-027 SHALL, with macro ALU_SEQ_DIV_EN defined, include the divider and DIV state per REQ-019/021.
REQ-028 SHALL, without ALU_SEQ_DIV_EN, omit divider logic; S_OP=101 completes as single-cycle with RES_OP=0, RES_HI=0, ZEROFLAG=1, DIVZERO=0, DONE after 1 edge.

Verification
REQ-029 SHALL cover: WIDTH=32, START add 0x7FFFFFFF+1 -> after 1 edge RES_OP=0x80000000, ZEROFLAG=0, DONE pulse; sub 5-5 -> RES_OP=0, ZEROFLAG=1.
REQ-030 SHALL cover: slt 0xFFFFFFFF vs 1 -> RES_OP=1; slt 1 vs 0xFFFFFFFF -> RES_OP=0.
REQ-031 SHALL cover: mul 0xFFFFFFFF*2 -> BUSY high 31 cycles, DONE 32 edges after START, RES_HI=1, RES_OP=0xFFFFFFFE; START pulses during BUSY ignored.
REQ-032 SHALL cover: divu 100/7 -> DONE after 32 edges, RES_OP=14, RES_HI=2, DIVZERO=0; divu 9/0 -> DONE after 1 edge, RES_OP=0xFFFFFFFF, RES_HI=9, DIVZERO=1.
REQ-033 SHALL cover: RST asserted 10 cycles into mul -> immediate BUSY=0, RES_OP=0, ZEROFLAG=1, no DONE after release.
REQ-034 SHALL cover: build without ALU_SEQ_DIV_EN, divu 100/7 -> DONE after 1 edge, RES_OP=0, ZEROFLAG=1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with 1-cycle logic/arith ops, shift-add multiply and optional restoring divide (ALU_SEQ_DIV_EN)
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       S_OP,
  input  logic [WIDTH-1:0] INOP1,
  input  logic [WIDTH-1:0] INOP2,
  output logic [WIDTH-1:0] RES_OP,
  output logic [WIDTH-1:0] RES_HI,
  output logic             ZEROFLAG,
  output logic             DIVZERO,
  output logic             BUSY,
  output logic             DONE
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] p, nxt, mul_nxt;
  logic [WIDTH-1:0] b, alu_res;
  logic [WIDTH:0] mul_sum;
`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0] shifted, diff;
  logic [2*WIDTH-1:0] div_nxt;
`endif
  // single-cycle result and one iteration step of the active multi-cycle op; p holds {hi, lo}
  always_comb begin
    alu_res = S_OP == 3'b000 ? INOP1 & INOP2 :
              S_OP == 3'b001 ? INOP1 | INOP2 :
              S_OP == 3'b010 ? INOP1 + INOP2 :
              S_OP == 3'b110 ? INOP1 - INOP2 :
              S_OP == 3'b111 ? {{(WIDTH-1){1'b0}}, $signed(INOP1) < $signed(INOP2)} : '0;
    mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, b & {WIDTH{p[0]}}};
    mul_nxt = {mul_sum, p[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    shifted = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    diff = shifted - {1'b0, b};
    div_nxt = {diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0], p[WIDTH-2:0], ~diff[WIDTH]};
    nxt = state == DIV ? div_nxt : mul_nxt;
`else
    nxt = mul_nxt;
`endif
  end
  // control FSM, operand capture, iteration and registered results
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      p <= '0;
      b <= '0;
      RES_OP <= '0;
      RES_HI <= '0;
      ZEROFLAG <= 1'b1;
      DIVZERO <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state == IDLE) begin
        if (START) begin
          if (S_OP == 3'b100) begin
            state <= MUL;
            p <= {{WIDTH{1'b0}}, INOP1};
            b <= INOP2;
            cnt <= '0;
          end
`ifdef ALU_SEQ_DIV_EN
          else if (S_OP == 3'b101 && INOP2 != '0) begin
            state <= DIV;
            p <= {{WIDTH{1'b0}}, INOP1};
            b <= INOP2;
            cnt <= '0;
          end else if (S_OP == 3'b101) begin
            RES_OP <= '1;
            RES_HI <= INOP1;
            ZEROFLAG <= 1'b0;
            DIVZERO <= 1'b1;
            DONE <= 1'b1;
          end
`endif
          else begin
            RES_OP <= alu_res;
            RES_HI <= '0;
            ZEROFLAG <= alu_res == '0;
            DIVZERO <= 1'b0;
            DONE <= 1'b1;
          end
        end
      end else begin
        p <= nxt;
        cnt <= cnt + 1'b1;
        BUSY <= 1'b1;
        if (cnt == CW'(WIDTH-1)) begin
          state <= IDLE;
          cnt <= '0;
          BUSY <= 1'b0;
          DONE <= 1'b1;
          RES_HI <= nxt[2*WIDTH-1:WIDTH];
          RES_OP <= nxt[WIDTH-1:0];
          ZEROFLAG <= nxt[WIDTH-1:0] == '0;
          DIVZERO <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=32), divider expectations follow ALU_SEQ_DIV_EN
module tb_alu_seq;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic START = 1'b0;
  logic [2:0] S_OP = 3'b011;
  logic [31:0] INOP1 = '0;
  logic [31:0] INOP2 = '0;
  logic [31:0] RES_OP, RES_HI;
  logic ZEROFLAG, DIVZERO, BUSY, DONE;
  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .S_OP(S_OP), .INOP1(INOP1), .INOP2(INOP2),
    .RES_OP(RES_OP), .RES_HI(RES_HI), .ZEROFLAG(ZEROFLAG), .DIVZERO(DIVZERO),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // called at a negedge; returns at the negedge after the START edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] bb);
    START = 1'b1;
    S_OP = op;
    INOP1 = a;
    INOP2 = bb;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if ({RES_OP, RES_HI, ZEROFLAG, DIVZERO, BUSY, DONE} !== {32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: op=%h hi=%h zf=%b dz=%b busy=%b done=%b expected 0 0 1 0 0 0", RES_OP, RES_HI, ZEROFLAG, DIVZERO, BUSY, DONE);
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (DONE !== 1'b0) begin errors++; $display("FAIL reset_nodone: done=%b expected 0", DONE); end
  endtask

  task automatic test_single;
    issue(3'b010, 32'h7FFF_FFFF, 32'h1);
    checks++;
    if ({DONE, RES_OP, RES_HI, ZEROFLAG} !== {1'b1, 32'h8000_0000, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL add: done=%b op=%h hi=%h zf=%b expected 1 80000000 0 0", DONE, RES_OP, RES_HI, ZEROFLAG);
    end
    @(negedge CLK);
    checks++;
    if ({DONE, RES_OP} !== {1'b0, 32'h8000_0000}) begin
      errors++;
      $display("FAIL add_hold: done=%b op=%h expected 0 80000000", DONE, RES_OP);
    end
    issue(3'b110, 32'd5, 32'd5);
    checks++;
    if ({DONE, RES_OP, ZEROFLAG} !== {1'b1, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL sub: done=%b op=%h zf=%b expected 1 0 1", DONE, RES_OP, ZEROFLAG);
    end
    issue(3'b110, 32'd3, 32'd5);
    checks++;
    if (RES_OP !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_wrap: op=%h expected fffffffe", RES_OP); end
    issue(3'b000, 32'hF0F0_00FF, 32'h0FF0_FF0F);
    checks++;
    if (RES_OP !== 32'h00F0_000F) begin errors++; $display("FAIL and: op=%h expected 00f0000f", RES_OP); end
    issue(3'b001, 32'hF0F0_00FF, 32'h0FF0_FF0F);
    checks++;
    if (RES_OP !== 32'hFFF0_FFFF) begin errors++; $display("FAIL or: op=%h expected fff0ffff", RES_OP); end
    issue(3'b111, 32'hFFFF_FFFF, 32'h1);
    checks++;
    if ({RES_OP, ZEROFLAG} !== {32'h1, 1'b0}) begin errors++; $display("FAIL slt_neg: op=%h zf=%b expected 1 0", RES_OP, ZEROFLAG); end
    issue(3'b111, 32'h1, 32'hFFFF_FFFF);
    checks++;
    if ({RES_OP, ZEROFLAG} !== {32'h0, 1'b1}) begin errors++; $display("FAIL slt_pos: op=%h zf=%b expected 0 1", RES_OP, ZEROFLAG); end
    issue(3'b011, 32'h1234, 32'h5678);
    checks++;
    if ({DONE, RES_OP, RES_HI, ZEROFLAG} !== {1'b1, 32'h0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL nop: done=%b op=%h hi=%h zf=%b expected 1 0 0 1", DONE, RES_OP, RES_HI, ZEROFLAG);
    end
  endtask

  task automatic test_back_to_back;
    START = 1'b1; S_OP = 3'b010; INOP1 = 32'd1; INOP2 = 32'd2;
    @(negedge CLK);
    checks++;
    if ({DONE, RES_OP} !== {1'b1, 32'd3}) begin errors++; $display("FAIL b2b_first: done=%b op=%h expected 1 3", DONE, RES_OP); end
    S_OP = 3'b001; INOP1 = 32'd4; INOP2 = 32'd8;
    @(negedge CLK);
    checks++;
    if ({DONE, RES_OP} !== {1'b1, 32'd12}) begin errors++; $display("FAIL b2b_second: done=%b op=%h expected 1 c", DONE, RES_OP); end
    START = 1'b0;
    @(negedge CLK);
    checks++;
    if ({DONE, RES_OP} !== {1'b0, 32'd12}) begin errors++; $display("FAIL b2b_hold: done=%b op=%h expected 0 c", DONE, RES_OP); end
  endtask

  // waits for DONE from the negedge after the START edge; returns edges elapsed and BUSY-high cycles
  task automatic wait_done(output int n, output int busy_cnt, input bit poke);
    n = 0;
    busy_cnt = 0;
    while (!DONE && n < 100) begin
      if (BUSY) busy_cnt++;
      START = poke && (n == 5 || n == 10);
      S_OP = 3'b010;
      INOP1 = 32'h0BAD_0000 + 32'(n);
      INOP2 = 32'h1;
      @(negedge CLK);
      n++;
    end
    START = 1'b0;
  endtask

  task automatic test_mul;
    int n, bc;
    logic [63:0] prod;
    issue(3'b100, 32'hFFFF_FFFF, 32'h2);
    wait_done(n, bc, 1'b1);
    checks++;
    if (n !== 32) begin errors++; $display("FAIL mul_latency: edges=%0d expected 32", n); end
    checks++;
    if (bc !== 31) begin errors++; $display("FAIL mul_busy: cycles=%0d expected 31", bc); end
    checks++;
    if ({RES_HI, RES_OP, ZEROFLAG, DIVZERO} !== {32'h1, 32'hFFFF_FFFE, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mul_result: hi=%h op=%h zf=%b dz=%b expected 1 fffffffe 0 0", RES_HI, RES_OP, ZEROFLAG, DIVZERO);
    end
    issue(3'b010, 32'd7, 32'd8);
    checks++;
    if ({DONE, RES_OP, RES_HI} !== {1'b1, 32'd15, 32'h0}) begin
      errors++;
      $display("FAIL start_on_done: done=%b op=%h hi=%h expected 1 f 0", DONE, RES_OP, RES_HI);
    end
    prod = 64'h1234_5678 * 64'h9ABC_DEF0;
    issue(3'b100, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_done(n, bc, 1'b0);
    checks++;
    if ({n, RES_HI, RES_OP} !== {32'd32, prod}) begin
      errors++;
      $display("FAIL mul_big: edges=%0d hi=%h op=%h expected 32 %h", n, RES_HI, RES_OP, prod);
    end
    @(negedge CLK);
    checks++;
    if ({DONE, BUSY, RES_OP} !== {1'b0, 1'b0, prod[31:0]}) begin
      errors++;
      $display("FAIL mul_hold: done=%b busy=%b op=%h expected 0 0 %h", DONE, BUSY, RES_OP, prod[31:0]);
    end
  endtask

  task automatic test_div;
`ifdef ALU_SEQ_DIV_EN
    int n, bc;
    issue(3'b101, 32'd100, 32'd7);
    wait_done(n, bc, 1'b1);
    checks++;
    if ({n, RES_OP, RES_HI, DIVZERO, ZEROFLAG} !== {32'd32, 32'd14, 32'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL divu: edges=%0d q=%0d r=%0d dz=%b zf=%b expected 32 14 2 0 0", n, RES_OP, RES_HI, DIVZERO, ZEROFLAG);
    end
    issue(3'b101, 32'd9, 32'd0);
    checks++;
    if ({DONE, BUSY, RES_OP, RES_HI, DIVZERO, ZEROFLAG} !== {1'b1, 1'b0, 32'hFFFF_FFFF, 32'd9, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL divzero: done=%b busy=%b op=%h hi=%h dz=%b zf=%b expected 1 0 ffffffff 9 1 0", DONE, BUSY, RES_OP, RES_HI, DIVZERO, ZEROFLAG);
    end
    issue(3'b010, 32'd1, 32'd1);
    checks++;
    if ({RES_OP, DIVZERO} !== {32'd2, 1'b0}) begin errors++; $display("FAIL divzero_clear: op=%h dz=%b expected 2 0", RES_OP, DIVZERO); end
`else
    issue(3'b101, 32'd100, 32'd7);
    checks++;
    if ({DONE, BUSY, RES_OP, RES_HI, ZEROFLAG, DIVZERO} !== {1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL divu_disabled: done=%b busy=%b op=%h hi=%h zf=%b dz=%b expected 1 0 0 0 1 0", DONE, BUSY, RES_OP, RES_HI, ZEROFLAG, DIVZERO);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int seen;
    issue(3'b010, 32'd20, 32'd22);
    issue(3'b100, 32'hFFFF_FFFF, 32'h2);
    repeat (10) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL mid_busy: busy=%b expected 1", BUSY); end
    RST = 1'b1;
    #1;
    checks++;
    if ({BUSY, DONE, RES_OP, RES_HI, ZEROFLAG, DIVZERO} !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b op=%h hi=%h zf=%b dz=%b expected 0 0 0 0 1 0", BUSY, DONE, RES_OP, RES_HI, ZEROFLAG, DIVZERO);
    end
    @(negedge CLK);
    RST = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE || BUSY) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_no_done: cycles with done/busy=%0d expected 0", seen); end
    issue(3'b010, 32'd2, 32'd3);
    checks++;
    if ({DONE, RES_OP} !== {1'b1, 32'd5}) begin errors++; $display("FAIL after_reset: done=%b op=%h expected 1 5", DONE, RES_OP); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_mul;
    test_div;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
